// File: rtl/rs232_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, 8 data bits LSB first,
// one parity bit and one stop bit, with a one-cycle ready strobe per frame.
`timescale 1ns/1ps
module rs232_rx #(
  parameter int BAUD_DIV = 10416,
  parameter bit ODD_PAR  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       rdy_o,
  output logic       perr_o,
  output logic       ferr_o,
  output logic       busy_o
);

  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic          rx_p0, rx_p1, rx_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bidx, bidx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          par_bit, par_nxt;
  logic          frame_done;

  function automatic logic par_err(input logic [7:0] d, input logic p);
    return (^d ^ p) != ODD_PAR;
  endfunction

  // Synchroniser stage: idles high so reset never looks like a start bit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // State register stage
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bidx    <= 3'd0;
      shift   <= 8'h00;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bidx    <= bidx_nxt;
      shift   <= shift_nxt;
      par_bit <= par_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (cnt == CNT_HALF) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (cnt == CNT_LAST && bidx == 3'd7) state_nxt = PARITY;
      PARITY:  if (cnt == CNT_LAST) state_nxt = STOP;
      STOP:    if (cnt == CNT_LAST) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    // The bit counter wraps explicitly because BAUD_DIV need not be a power of two
    if (state_nxt != state || state == IDLE || cnt == CNT_LAST) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
    bidx_nxt   = bidx;
    shift_nxt  = shift;
    par_nxt    = par_bit;
    frame_done = 1'b0;
    case (state)
      START: begin
        if (cnt == CNT_HALF && !rx_s) bidx_nxt = 3'd0;
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_nxt[bidx] = rx_s;
          bidx_nxt        = bidx + 3'd1;
        end
      end
      PARITY: begin
        if (cnt == CNT_LAST) par_nxt = rx_s;
      end
      STOP: begin
        if (cnt == CNT_LAST) frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Output register stage: results hold between ready strobes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o <= 8'h00;
      rdy_o  <= 1'b0;
      perr_o <= 1'b0;
      ferr_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      rdy_o  <= frame_done;
      busy_o <= (state != IDLE);
      if (frame_done) begin
        data_o <= shift;
        perr_o <= par_err(shift, par_bit);
        ferr_o <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_rs232_rx.sv
// Bench for rs232_rx: an even- and an odd-parity receiver share one serial line
// and are compared against a frame-level model of what each frame must yield.
`timescale 1ns/1ps
module tb_rs232_rx;

  localparam int BD   = 16;
  localparam int HALF = BD / 2;
  // 2 synchroniser edges + 1 edge into START, then half a bit plus ten bit periods
  localparam int LAT  = 3 + HALF + 10 * BD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_ev, data_od;
  logic       rdy_ev, rdy_od, perr_ev, perr_od, ferr_ev, ferr_od, busy_ev, busy_od;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [7:0] hold_d = 8'h00;
  logic       hold_pe_ev = 1'b0, hold_pe_od = 1'b0, hold_fe = 1'b0;
  int         rdy_prev = 0, rdy_last = 0;
  int         ones;

  rs232_rx #(.BAUD_DIV(BD), .ODD_PAR(1'b0)) dut_ev (
    .clk_i(clk), .rst_i(rst_n), .rx_i(rx),
    .data_o(data_ev), .rdy_o(rdy_ev), .perr_o(perr_ev), .ferr_o(ferr_ev), .busy_o(busy_ev)
  );

  rs232_rx #(.BAUD_DIV(BD), .ODD_PAR(1'b1)) dut_od (
    .clk_i(clk), .rst_i(rst_n), .rx_i(rx),
    .data_o(data_od), .rdy_o(rdy_od), .perr_o(perr_od), .ferr_o(ferr_od), .busy_o(busy_od)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Frame-level model: parity judged by counting ones, framing by the stop bit
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_d     = 8'h00;
      hold_pe_ev = 1'b0;
      hold_pe_od = 1'b0;
      hold_fe    = 1'b0;
    end else if (rdy_ev || rdy_od) begin
      chk("rdy_pair", {rdy_ev, rdy_od}, 2'b11);
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_rdy: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        ones       = $countones({e.d, e.p});
        hold_d     = e.d;
        hold_pe_ev = (ones % 2) != 0;
        hold_pe_od = (ones % 2) == 0;
        hold_fe    = ~e.s;
        n_chk++;
        if (cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
          n_err++;
          $display("FAIL rdy_time: got cycle %0d expected %0d", cyc, e.cyc);
        end
        rdy_prev = rdy_last;
        rdy_last = cyc;
      end
      chk("frame_out", {data_ev, perr_ev, ferr_ev, data_od, perr_od, ferr_od},
          {hold_d, hold_pe_ev, hold_fe, hold_d, hold_pe_od, hold_fe});
    end else begin
      chk("hold_out", {data_ev, perr_ev, ferr_ev, data_od, perr_od, ferr_od},
          {hold_d, hold_pe_ev, hold_fe, hold_d, hold_pe_od, hold_fe});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b);
    rx = b;
    step(BD);
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic s, input bit push);
    exp_t x;
    if (push) begin
      x.d = d; x.p = p; x.s = s; x.cyc = cyc + LAT;
      q.push_back(x);
    end
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(d[i]);
    drive(p);
    drive(s);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      step(1);
      n++;
    end
    chk("rdy_timeout_pending", q.size(), 0);
  endtask

  task automatic lit(input string name, input logic [7:0] d, input logic pe_ev, input logic pe_od,
                     input logic fe);
    chk({name, "_data"}, {data_ev, data_od}, {d, d});
    chk({name, "_perr"}, {perr_ev, perr_od}, {pe_ev, pe_od});
    chk({name, "_ferr"}, {ferr_ev, ferr_od}, {fe, fe});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    bit broke;
    int n, c0;

    step(4);
    chk("reset_outs_ev", {data_ev, rdy_ev, perr_ev, ferr_ev, busy_ev}, 12'h000);
    chk("reset_outs_od", {data_od, rdy_od, perr_od, ferr_od, busy_od}, 12'h000);
    rst_n = 1'b1;
    step(3);

    send(8'hA5, 1'b0, 1'b1, 1'b1);
    wait_drain();
    lit("a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    step(20);

    send(8'h07, 1'b0, 1'b1, 1'b1);
    wait_drain();
    lit("07p0", 8'h07, 1'b1, 1'b0, 1'b0);
    step(20);
    send(8'h07, 1'b1, 1'b1, 1'b1);
    wait_drain();
    lit("07p1", 8'h07, 1'b0, 1'b1, 1'b0);
    step(20);

    // Stop bit low followed by a held break
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    broke = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy_ev || !busy_od) broke = 1'b1;
      step(1);
    end
    chk("busy_in_break", broke, 1'b0);
    wait_drain();
    lit("3c", 8'h3C, 1'b0, 1'b1, 1'b1);
    rx = 1'b1;
    n = 0;
    while ((busy_ev || busy_od) && n < 8) begin
      step(1);
      n++;
    end
    chk("busy_after_break", {busy_ev, busy_od}, 2'b00);
    step(20);
    send(8'h11, 1'b0, 1'b1, 1'b1);
    wait_drain();
    lit("11", 8'h11, 1'b0, 1'b1, 1'b0);

    // Short glitch shorter than half a bit
    step(10);
    rx = 1'b0;
    step(5);
    rx = 1'b1;
    chk("glitch_busy_seen", {busy_ev, busy_od}, 2'b11);
    n = 0;
    while ((busy_ev || busy_od) && n < HALF + 3) begin
      step(1);
      n++;
    end
    chk("glitch_busy_low", {busy_ev, busy_od}, 2'b00);
    step(30);
    lit("glitch_hold", 8'h11, 1'b0, 1'b1, 1'b0);

    // Back-to-back frames, no idle between stop and start
    send(8'h55, 1'b0, 1'b1, 1'b1);
    send(8'hAA, 1'b0, 1'b1, 1'b1);
    wait_drain();
    lit("aa", 8'hAA, 1'b0, 1'b1, 1'b0);
    chk("b2b_spacing", rdy_last - rdy_prev, 11 * BD);

    // Reset asserted during data bit 4 of a frame that must be discarded
    step(20);
    c0 = cyc;
    fork
      send(8'h9E, 1'b1, 1'b1, 1'b0);
      begin
        while (cyc < c0 + 5 * BD + HALF) step(1);
        chk("busy_before_rst", {busy_ev, busy_od}, 2'b11);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ev", {data_ev, rdy_ev, perr_ev, ferr_ev, busy_ev}, 12'h000);
        chk("rst_async_od", {data_od, rdy_od, perr_od, ferr_od, busy_od}, 12'h000);
      end
    join
    step(5);
    rst_n = 1'b1;
    step(20);
    chk("post_rst_idle", {data_ev, busy_ev, data_od, busy_od}, 18'h0);
    send(8'hC3, 1'b0, 1'b1, 1'b1);
    wait_drain();
    lit("c3", 8'hC3, 1'b0, 1'b1, 1'b0);
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
